// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core: OP, OP-IMM, LUI and AUIPC executed over a
// FETCH -> DECODE -> EXECUTE -> WRITEBACK sequence with a req/ack instruction fetch.
module rv32_multicycle_core #(
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic        illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [5:0] NREGS_L   = 6'(NREGS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [2:0]  alu_f3_q, alu_f3_d;
  logic        alu_alt_q, alu_alt_d;
  logic        legal_q, legal_d;
  logic [31:0] result_q, result_d;
  logic [31:0] retire_pc_q, retire_pc_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;
  // x0 has no storage; reads of index 0 fall through to the zero default.
  logic [31:0] regs_q [1:NREGS-1];
  logic [31:0] regs_d [1:NREGS-1];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, rs1_val, rs2_val, alu_y;
  logic [31:0] dec_a, dec_b;
  logic [2:0]  dec_f3;
  logic        dec_alt, dec_legal;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u  = {ir_q[31:12], 12'd0};

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  always_comb begin
    rs1_val   = '0;
    rs2_val   = '0;
    dbg_rdata = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1 == 5'(i))       rs1_val   = regs_q[i];
      if (rs2 == 5'(i))       rs2_val   = regs_q[i];
      if (dbg_raddr == 5'(i)) dbg_rdata = regs_q[i];
    end
  end

  // Decode maps every supported form onto the OP-style ALU (funct3 + alternate bit).
  always_comb begin
    dec_legal = 1'b0;
    dec_f3    = funct3;
    dec_alt   = 1'b0;
    dec_a     = rs1_val;
    dec_b     = rs2_val;
    case (opcode)
      OPC_OP: begin
        dec_alt   = funct7[5];
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_legal = dec_legal && idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd);
      end
      OPC_OPIMM: begin
        dec_b   = imm_i;
        dec_alt = (funct3 == 3'b101) && funct7[5];
        if (funct3 == 3'b001)      dec_legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       dec_legal = 1'b1;
        dec_legal = dec_legal && idx_ok(rs1) && idx_ok(rd);
      end
      OPC_LUI: begin
        dec_a     = '0;
        dec_b     = imm_u;
        dec_f3    = 3'b000;
        dec_legal = idx_ok(rd);
      end
      OPC_AUIPC: begin
        dec_a     = pc_q;
        dec_b     = imm_u;
        dec_f3    = 3'b000;
        dec_legal = idx_ok(rd);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_f3_q)
      3'b000: alu_y = alu_alt_q ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
      3'b001: alu_y = op_a_q << op_b_q[4:0];
      3'b010: alu_y = {31'd0, $signed(op_a_q) < $signed(op_b_q)};
      3'b011: alu_y = {31'd0, op_a_q < op_b_q};
      3'b100: alu_y = op_a_q ^ op_b_q;
      3'b101: alu_y = alu_alt_q ? 32'($signed(op_a_q) >>> op_b_q[4:0]) : (op_a_q >> op_b_q[4:0]);
      3'b110: alu_y = op_a_q | op_b_q;
      3'b111: alu_y = op_a_q & op_b_q;
      default: alu_y = '0;
    endcase
  end

  assign imem_req  = (state_q == S_FETCH) && !reset;
  assign imem_addr = pc_q;
  assign retire    = retire_q && !reset;
  assign illegal   = illegal_q && !reset;
  assign retire_pc = retire_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    alu_f3_d    = alu_f3_q;
    alu_alt_d   = alu_alt_q;
    legal_d     = legal_q;
    result_d    = result_q;
    retire_pc_d = retire_pc_q;
    retire_d    = 1'b0;
    illegal_d   = 1'b0;
    regs_d      = regs_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d    = dec_a;
        op_b_d    = dec_b;
        alu_f3_d  = dec_f3;
        alu_alt_d = dec_alt;
        legal_d   = dec_legal;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        result_d = alu_y;
        state_d  = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        for (int i = 1; i < NREGS; i++) begin
          if (legal_q && (rd == 5'(i))) regs_d[i] = result_q;
        end
        retire_d    = legal_q;
        illegal_d   = !legal_q;
        retire_pc_d = pc_q;
        pc_d        = pc_q + 32'd4;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      alu_f3_q    <= '0;
      alu_alt_q   <= 1'b0;
      legal_q     <= 1'b0;
      result_q    <= '0;
      retire_pc_q <= '0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_f3_q    <= alu_f3_d;
      alu_alt_q   <= alu_alt_d;
      legal_q     <= legal_d;
      result_q    <= result_d;
      retire_pc_q <= retire_pc_d;
      retire_q    <= retire_d;
      illegal_q   <= illegal_d;
      for (int i = 1; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Bench for rv32_multicycle_core: an RV32I instance and an RV32E instance (RESET_PC 0x100),
// directed instruction stream, expected retire/illegal events queued and checked by a monitor.
module tb_rv32_multicycle_core;

  localparam int          W     = 70;  // {illegal, pc[31:0], reg idx[4:0], reg value[31:0]}
  localparam logic [31:0] DECOY = 32'h0630_0093;  // addi x1,x0,99 offered while req is low

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        imem_req_w   [2];
  logic [31:0] imem_addr_w  [2];
  logic        imem_ack_w   [2];
  logic [31:0] imem_rdata_w [2];
  logic        retire_w     [2];
  logic        illegal_w    [2];
  logic [31:0] retire_pc_w  [2];
  logic [4:0]  dbg_raddr_w  [2];
  logic [31:0] dbg_rdata_w  [2];

  logic [4:0] mon_idx [2] = '{5'd0, 5'd0};
  logic       peek_en;
  logic [4:0] peek_idx;
  assign dbg_raddr_w[0] = peek_en ? peek_idx : mon_idx[0];
  assign dbg_raddr_w[1] = mon_idx[1];

  rv32_multicycle_core #(.NREGS(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_w[0]), .imem_addr(imem_addr_w[0]),
    .imem_ack(imem_ack_w[0]), .imem_rdata(imem_rdata_w[0]),
    .retire(retire_w[0]), .retire_pc(retire_pc_w[0]), .illegal(illegal_w[0]),
    .dbg_raddr(dbg_raddr_w[0]), .dbg_rdata(dbg_rdata_w[0])
  );

  rv32_multicycle_core #(.NREGS(16), .RESET_PC(32'h0000_0100)) dut_e (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_w[1]), .imem_addr(imem_addr_w[1]),
    .imem_ack(imem_ack_w[1]), .imem_rdata(imem_rdata_w[1]),
    .retire(retire_w[1]), .retire_pc(retire_pc_w[1]), .illegal(illegal_w[1]),
    .dbg_raddr(dbg_raddr_w[1]), .dbg_rdata(dbg_rdata_w[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_start = 0;
  int last_ret = 0;
  int prev_ret = 0;
  logic [31:0]  exp_pc [2];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e_q[$];
  logic [W-1:0] mon_item;
  bit           mon_have;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every retire/illegal pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (retire_w[e] || illegal_w[e]) begin
        chk("pulse_exclusive", {31'd0, retire_w[e] & illegal_w[e]}, 32'd0);
        mon_have = 1'b0;
        if (e == 0 && exp_q.size() > 0) begin
          mon_item = exp_q.pop_front();
          mon_have = 1'b1;
        end else if (e == 1 && exp_e_q.size() > 0) begin
          mon_item = exp_e_q.pop_front();
          mon_have = 1'b1;
        end
        if (!mon_have) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse inst=%0d retire=%b illegal=%b expected=no pulse",
                   e, retire_w[e], illegal_w[e]);
        end else begin
          if (e == 0) begin
            prev_ret = last_ret;
            last_ret = cyc;
          end
          chk("pulse_kind_illegal", {31'd0, illegal_w[e]}, {31'd0, mon_item[69]});
          chk("retire_pc", retire_pc_w[e], mon_item[68:37]);
          mon_idx[e] = mon_item[36:32];
          #1;
          chk("reg_value", dbg_rdata_w[e], mon_item[31:0]);
        end
      end
    end
  end

  // Offer one instruction word to instance e after `waits` stall cycles.
  task automatic issue(input int e, input logic [31:0] instr, input int waits, input bit push,
                       input bit kind, input logic [4:0] idx, input logic [31:0] val);
    int n = 0;
    imem_rdata_w[e] = DECOY;
    imem_ack_w[e]   = 1'b1;
    while (!imem_req_w[e] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    imem_ack_w[e] = 1'b0;
    if (!imem_req_w[e]) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout inst=%0d imem_req=0 expected=1 within 50 cycles", e);
      return;
    end
    req_start = cyc;
    chk("imem_addr", imem_addr_w[e], exp_pc[e]);
    for (int k = 0; k < waits; k++) begin
      @(posedge clk); #1;
      chk("req_held", {31'd0, imem_req_w[e]}, 32'd1);
      chk("addr_stable", imem_addr_w[e], exp_pc[e]);
    end
    imem_rdata_w[e] = instr;
    imem_ack_w[e]   = 1'b1;
    if (push) begin
      if (e == 0) exp_q.push_back({kind, exp_pc[e], idx, val});
      else        exp_e_q.push_back({kind, exp_pc[e], idx, val});
    end
    @(posedge clk); #1;
    imem_ack_w[e] = 1'b0;
    exp_pc[e] = exp_pc[e] + 32'd4;
  endtask

  task automatic wait_idle(input int e);
    int n = 0;
    while (((e == 0) ? exp_q.size() : exp_e_q.size()) != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL drain_timeout inst=%0d pending=%0d expected=0", e,
               (e == 0) ? exp_q.size() : exp_e_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    peek_en  = 1'b0;
    peek_idx = 5'd0;
    for (int e = 0; e < 2; e++) begin
      imem_ack_w[e]   = 1'b0;
      imem_rdata_w[e] = '0;
    end
    exp_pc[0] = 32'h0000_0000;
    exp_pc[1] = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_imem_req", {31'd0, imem_req_w[0]}, 32'd0);
    chk("reset_retire", {31'd0, retire_w[0]}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_w[0]}, 32'd0);
    chk("reset_retire_pc", retire_pc_w[0], 32'd0);
    chk("reset_imem_addr", imem_addr_w[0], 32'h0000_0000);
    chk("reset_imem_req_e", {31'd0, imem_req_w[1]}, 32'd0);
    chk("reset_imem_addr_e", imem_addr_w[1], 32'h0000_0100);
    peek_en  = 1'b1;
    peek_idx = 5'd5;
    #1;
    chk("reset_reg_x5", dbg_rdata_w[0], 32'd0);
    peek_en = 1'b0;
    reset   = 1'b0;
    #1;
    chk("req_after_reset", {31'd0, imem_req_w[0]}, 32'd1);

    issue(0, 32'h0050_0093, 0, 1, 1'b0, 5'd1,  32'd5);          // addi x1,x0,5
    issue(0, 32'hFF90_8113, 0, 1, 1'b0, 5'd2,  32'hFFFF_FFFE);  // addi x2,x1,-7
    wait_idle(0);
    chk("retire_spacing", 32'(last_ret - prev_ret), 32'd4);

    issue(0, 32'h4011_5193, 0, 1, 1'b0, 5'd3,  32'hFFFF_FFFF);  // srai x3,x2,1
    issue(0, 32'h0011_5213, 0, 1, 1'b0, 5'd4,  32'h7FFF_FFFF);  // srli x4,x2,1
    issue(0, 32'h4020_02B3, 0, 1, 1'b0, 5'd5,  32'd2);          // sub x5,x0,x2
    issue(0, 32'hFFF0_B313, 0, 1, 1'b0, 5'd6,  32'd1);          // sltiu x6,x1,-1
    issue(0, 32'hFFF0_A393, 0, 1, 1'b0, 5'd7,  32'd0);          // slti x7,x1,-1
    issue(0, 32'h1234_5437, 0, 1, 1'b0, 5'd8,  32'h1234_5000);  // lui x8,0x12345
    issue(0, 32'h0000_1497, 0, 1, 1'b0, 5'd9,  32'h0000_1020);  // auipc x9,1 @0x20
    issue(0, 32'h0000_0000, 0, 1, 1'b1, 5'd1,  32'd5);          // all-zero word
    issue(0, 32'h0221_00B3, 0, 1, 1'b1, 5'd1,  32'd5);          // add, funct7=0000001
    issue(0, 32'h0010_9533, 0, 1, 1'b0, 5'd10, 32'h0000_00A0);  // sll x10,x1,x1
    issue(0, 32'h0020_C5B3, 0, 1, 1'b0, 5'd11, 32'hFFFF_FFFB);  // xor x11,x1,x2
    issue(0, 32'h0020_E633, 0, 1, 1'b0, 5'd12, 32'hFFFF_FFFF);  // or x12,x1,x2
    issue(0, 32'h0020_F6B3, 0, 1, 1'b0, 5'd13, 32'd4);          // and x13,x1,x2
    issue(0, 32'h0011_2733, 0, 1, 1'b0, 5'd14, 32'd1);          // slt x14,x2,x1
    issue(0, 32'h0011_37B3, 0, 1, 1'b0, 5'd15, 32'd0);          // sltu x15,x2,x1
    issue(0, 32'h4011_5833, 0, 1, 1'b0, 5'd16, 32'hFFFF_FFFF);  // sra x16,x2,x1
    wait_idle(0);

    issue(0, 32'h0010_88B3, 3, 1, 1'b0, 5'd17, 32'd10);         // add x17,x1,x1, ack late
    wait_idle(0);
    chk("ack_latency", 32'(last_ret - req_start), 32'd7);

    issue(0, 32'h4010_90B3, 0, 1, 1'b1, 5'd1,  32'd5);          // funct7=0100000 with sll
    issue(0, 32'h4010_9093, 0, 1, 1'b1, 5'd1,  32'd5);          // slli with imm[11:5]=0100000
    wait_idle(0);

    issue(0, 32'h0090_0093, 0, 0, 1'b0, 5'd1,  32'd9);          // addi x1,x0,9, abandoned
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("req_in_reset", {31'd0, imem_req_w[0]}, 32'd0);
    chk("retire_in_reset", {31'd0, retire_w[0]}, 32'd0);
    reset     = 1'b0;
    exp_pc[0] = 32'h0000_0000;
    exp_pc[1] = 32'h0000_0100;
    #1;
    chk("addr_after_midreset", imem_addr_w[0], 32'h0000_0000);
    peek_en  = 1'b1;
    peek_idx = 5'd1;
    #1;
    chk("x1_after_midreset", dbg_rdata_w[0], 32'd0);
    peek_en = 1'b0;
    issue(0, 32'h0030_0013, 0, 1, 1'b0, 5'd0,  32'd0);          // addi x0,x0,3
    wait_idle(0);

    issue(1, 32'h0010_0A13, 0, 1, 1'b1, 5'd20, 32'd0);          // addi x20,x0,1 on RV32E
    issue(1, 32'h0010_0793, 0, 1, 1'b0, 5'd15, 32'd1);          // addi x15,x0,1
    issue(1, 32'h0018_0093, 0, 1, 1'b1, 5'd1,  32'd0);          // addi x1,x16,1
    wait_idle(1);

    repeat (8) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
